// File: rtl/gearbox_upsizing_2x.sv
// Width-doubling stream gearbox: packs two W-bit input beats into one 2W-bit word.
// The first beat of each pair lands in the low half of the output word.
module gearbox_upsizing_2x #(
    parameter int unsigned W = 40
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [W-1:0]   in_tdata,
    input  logic           in_tvalid,
    output logic           in_tready,
    output logic [2*W-1:0] out_tdata,
    output logic           out_tvalid,
    input  logic           out_tready
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   lo_reg;
    logic           in_fire;

    // Only a second beat needs the output register, so a first beat is always welcome.
    assign in_tready = (state == EMPTY) || !out_tvalid || out_tready;
    assign in_fire   = in_tvalid && in_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= EMPTY;
            lo_reg     <= '0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
        end else begin
            if (out_tvalid && out_tready) begin
                out_tvalid <= 1'b0;
            end
            // A second-beat load overrides the clear above, keeping the stream bubble-free.
            if (in_fire) begin
                case (state)
                    EMPTY: begin
                        lo_reg <= in_tdata;
                        state  <= HALF;
                    end
                    HALF: begin
                        out_tdata  <= {in_tdata, lo_reg};
                        out_tvalid <= 1'b1;
                        state      <= EMPTY;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule
